// File: rtl/sprite_palette_pkg.sv
// Shared types and reset-time colour table for the sprite palette lookup.
// The default table is stored at 4 bits per channel and rescaled by the consumer.
package sprite_palette_pkg;

    localparam int PAL_CHAN_W      = 4;
    localparam int DEFAULT_ENTRIES = 16;

    typedef enum logic [1:0] {
        FLASH_IDLE = 2'd0,
        FLASH_ON   = 2'd1,
        FLASH_OFF  = 2'd2
    } flash_state_t;

    typedef struct packed {
        logic [PAL_CHAN_W-1:0] r;
        logic [PAL_CHAN_W-1:0] g;
        logic [PAL_CHAN_W-1:0] b;
    } rgb_t;

    localparam rgb_t DEFAULT_PALETTE [DEFAULT_ENTRIES] = '{
        12'hF0F, 12'hBA9, 12'h753, 12'hEEC,
        12'h111, 12'hA76, 12'hDCB, 12'hF20,
        12'hEA8, 12'hFFF, 12'hFB9, 12'hFDA,
        12'hB98, 12'hC97, 12'h876, 12'hC10
    };

    // Channel 0 = red, 1 = green, 2 = blue; entries past the table are black.
    function automatic logic [3:0] default_nibble(input int idx, input int ch);
        rgb_t c;
        if (idx < 0 || idx >= DEFAULT_ENTRIES) return 4'h0;
        c = DEFAULT_PALETTE[idx[3:0]];
        case (ch)
            0:       return c.r;
            1:       return c.g;
            default: return c.b;
        endcase
    endfunction

endpackage

// File: rtl/palette_flash_fsm.sv
// Hit-flash sequencer: alternates ON/OFF once per frame tick for FLASH_TICKS ticks.
// A new flash_start always restarts the sequence, even on a tick cycle.
module palette_flash_fsm
    import sprite_palette_pkg::*;
#(
    parameter int FLASH_TICKS = 8,
    localparam int CNT_W = $clog2(FLASH_TICKS + 1)
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       flash_start,
    input  logic       frame_tick,
    output logic       flash_on,
    output logic       flash_active,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE = FLASH_IDLE;
    localparam logic [1:0] ST_ON   = FLASH_ON;
    localparam logic [1:0] ST_OFF  = FLASH_OFF;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flash_start) begin
            state_d = ST_ON;
            cnt_d   = CNT_W'(FLASH_TICKS);
        end else if (frame_tick && state_q != ST_IDLE) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
                state_d = ST_IDLE;
            else
                state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            flash_active <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flash_active <= (state_d != ST_IDLE);
        end
    end

    assign flash_on = (state_q == ST_ON);
    assign state    = state_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-bank runtime-writable sprite palette with a 2-stage registered lookup,
// chroma-key transparency and a frame-timed hit-flash overlay.
module sprite_palette_lut
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W         = 4,
    parameter int NUM_BANKS       = 4,
    parameter int CHAN_W          = 4,
    parameter int TRANSPARENT_IDX = 0,
    parameter int FLASH_TICKS     = 8,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int RGB_W  = 3 * CHAN_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid_in,
    input  logic [BANK_W-1:0]  bank_sel,
    input  logic [INDEX_W-1:0] index,
    output logic               pix_valid_out,
    output logic [CHAN_W-1:0]  red,
    output logic [CHAN_W-1:0]  green,
    output logic [CHAN_W-1:0]  blue,
    output logic               transparent,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [RGB_W-1:0]   wr_color,
    input  logic               flash_start,
    input  logic               frame_tick,
    output logic               flash_active,
    output logic [1:0]         flash_state
);

    localparam int ENTRIES = 2 ** INDEX_W;

    // Top CHAN_W bits of {nibble, zeros}: MSB-aligned rescale of the 4-bit defaults.
    function automatic logic [CHAN_W-1:0] scale_nibble(input logic [3:0] nib);
        logic [CHAN_W+3:0] wide;
        wide = {nib, {CHAN_W{1'b0}}};
        return wide[CHAN_W+3:4];
    endfunction

    function automatic logic [RGB_W-1:0] default_entry(input int idx);
        return {scale_nibble(default_nibble(idx, 0)),
                scale_nibble(default_nibble(idx, 1)),
                scale_nibble(default_nibble(idx, 2))};
    endfunction

    logic [RGB_W-1:0]   mem [NUM_BANKS][ENTRIES];
    logic               s1_valid;
    logic [BANK_W-1:0]  s1_bank;
    logic [INDEX_W-1:0] s1_index;
    logic               s1_bank_ok;
    logic               wr_ok;
    logic [RGB_W-1:0]   rd_entry;
    logic               flash_on;

    palette_flash_fsm #(
        .FLASH_TICKS(FLASH_TICKS)
    ) u_flash (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .flash_start (flash_start),
        .frame_tick  (frame_tick),
        .flash_on    (flash_on),
        .flash_active(flash_active),
        .state       (flash_state)
    );

    assign wr_ok      = (32'(wr_bank) < NUM_BANKS);
    assign s1_bank_ok = (32'(s1_bank) < NUM_BANKS);

    always_comb begin
        rd_entry = '0;
        if (s1_bank_ok) rd_entry = mem[s1_bank][s1_index];
    end

    // Palette storage; a write and a stage-2 read on the same edge return the old value.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < ENTRIES; i++)
                    mem[b][i] <= default_entry(i);
        end else if (wr_en && wr_ok) begin
            mem[wr_bank][wr_index] <= wr_color;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_bank  <= '0;
            s1_index <= '0;
        end else begin
            s1_valid <= pix_valid_in;
            s1_bank  <= bank_sel;
            s1_index <= index;
        end
    end

    // Stage 2: data registers update every cycle; only pix_valid_out tracks validity.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_valid_out <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
            transparent   <= 1'b0;
        end else begin
            pix_valid_out <= s1_valid;
            if (!s1_bank_ok || s1_index == INDEX_W'(TRANSPARENT_IDX)) begin
                red         <= '0;
                green       <= '0;
                blue        <= '0;
                transparent <= 1'b1;
            end else if (flash_on) begin
                red         <= '1;
                green       <= '1;
                blue        <= '1;
                transparent <= 1'b0;
            end else begin
                red         <= rd_entry[3*CHAN_W-1:2*CHAN_W];
                green       <= rd_entry[2*CHAN_W-1:CHAN_W];
                blue        <= rd_entry[CHAN_W-1:0];
                transparent <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut (3 banks, so bank 3 is out of range):
// expected pixels are queued with their arrival cycle and popped by a monitor.
module tb_sprite_palette_lut;

    localparam int INDEX_W   = 4;
    localparam int NUM_BANKS = 3;
    localparam int CHAN_W    = 4;
    localparam int BANK_W    = 2;

    logic               Clk;
    logic               Reset_n;
    logic               pix_valid_in;
    logic [BANK_W-1:0]  bank_sel;
    logic [INDEX_W-1:0] index;
    logic               pix_valid_out;
    logic [CHAN_W-1:0]  red, green, blue;
    logic               transparent;
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [11:0]        wr_color;
    logic               flash_start;
    logic               frame_tick;
    logic               flash_active;
    logic [1:0]         flash_state;

    // {transparent, r, g, b}
    logic [12:0] exp_q[$];
    int          exp_cyc_q[$];
    int          cyc;
    int          n_cmp;
    int          n_err;

    sprite_palette_lut #(
        .INDEX_W        (INDEX_W),
        .NUM_BANKS      (NUM_BANKS),
        .CHAN_W         (CHAN_W),
        .TRANSPARENT_IDX(0),
        .FLASH_TICKS    (8)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .pix_valid_in (pix_valid_in),
        .bank_sel     (bank_sel),
        .index        (index),
        .pix_valid_out(pix_valid_out),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .transparent  (transparent),
        .wr_en        (wr_en),
        .wr_bank      (wr_bank),
        .wr_index     (wr_index),
        .wr_color     (wr_color),
        .flash_start  (flash_start),
        .frame_tick   (frame_tick),
        .flash_active (flash_active),
        .flash_state  (flash_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        pix_valid_in = 1'b0;
        bank_sel     = '0;
        index        = '0;
        wr_en        = 1'b0;
        wr_bank      = '0;
        wr_index     = '0;
        wr_color     = '0;
        flash_start  = 1'b0;
        frame_tick   = 1'b0;
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
        clear_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) nxt();
    endtask

    // Drive a pixel in the current cycle; its result is due two edges later.
    task automatic pix(input logic [BANK_W-1:0] b, input logic [INDEX_W-1:0] i,
                       input logic t, input logic [11:0] rgb);
        pix_valid_in = 1'b1;
        bank_sel     = b;
        index        = i;
        exp_q.push_back({t, rgb});
        exp_cyc_q.push_back(cyc + 2);
    endtask

    task automatic pix_noexp(input logic [BANK_W-1:0] b, input logic [INDEX_W-1:0] i);
        pix_valid_in = 1'b1;
        bank_sel     = b;
        index        = i;
    endtask

    task automatic wr(input logic [BANK_W-1:0] b, input logic [INDEX_W-1:0] i,
                      input logic [11:0] c);
        wr_en    = 1'b1;
        wr_bank  = b;
        wr_index = i;
        wr_color = c;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge Clk) begin
        if (Reset_n && pix_valid_out) begin
            logic [12:0] e;
            int          ec;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got %0h at cycle %0d expected none",
                         {transparent, red, green, blue}, cyc);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if ({transparent, red, green, blue} !== e || cyc != ec) begin
                    n_err++;
                    $display("FAIL pixel: got %0h at cycle %0d expected %0h at cycle %0d",
                             {transparent, red, green, blue}, cyc, e, ec);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        n_cmp   = 0;
        n_err   = 0;
        Reset_n = 1'b0;
        clear_inputs();

        repeat (3) @(posedge Clk);
        #2;
        check("reset_outputs", {27'd0, pix_valid_out, transparent, red, green, blue} == 0 ? 32'd0 : 32'd1, 32'd0);
        check("reset_flash_active", {31'd0, flash_active}, 32'd0);
        check("reset_flash_state", {30'd0, flash_state}, 32'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        idle(2);

        // Default palette lookups, back to back
        pix(0, 1, 1'b0, 12'hBA9);  nxt();
        pix(0, 7, 1'b0, 12'hF20);  nxt();
        pix(0, 15, 1'b0, 12'hC10); nxt();
        idle(3);

        // Transparency and out-of-range bank
        pix(2, 0, 1'b1, 12'h000); nxt();
        pix(3, 9, 1'b1, 12'h000); nxt();
        pix(1, 9, 1'b0, 12'hFFF); nxt();
        idle(3);

        // Write collision: first read sees old value, later reads see new one
        pix(1, 5, 1'b0, 12'hA76); nxt();
        wr(1, 5, 12'h3C7);
        pix(1, 5, 1'b0, 12'h3C7); nxt();
        pix(0, 5, 1'b0, 12'hA76); nxt();
        wr(3, 7, 12'h5A5);
        pix(2, 7, 1'b0, 12'hF20); nxt();
        pix(1, 5, 1'b0, 12'h3C7); nxt();
        idle(3);

        // Full flash sequence
        flash_start = 1'b1; nxt();
        check("flash_active_start", {31'd0, flash_active}, 32'd1);
        idle(1);
        for (int t = 0; t < 8; t++) begin
            pix(0, 3, 1'b0, (t % 2 == 0) ? 12'hFFF : 12'hEEC); nxt();
            pix(0, 0, 1'b1, 12'h000); nxt();
            nxt();
            frame_tick = 1'b1; nxt();
            check($sformatf("flash_active_tick%0d", t + 1), {31'd0, flash_active},
                  (t < 7) ? 32'd1 : 32'd0);
        end
        pix(0, 3, 1'b0, 12'hEEC); nxt();
        idle(3);

        // Restart coinciding with the final tick
        flash_start = 1'b1; nxt();
        idle(1);
        for (int t = 0; t < 7; t++) begin
            frame_tick = 1'b1; nxt();
        end
        check("flash_state_count1", {30'd0, flash_state}, 32'd2);
        flash_start = 1'b1;
        frame_tick  = 1'b1;
        nxt();
        check("restart_active", {31'd0, flash_active}, 32'd1);
        check("restart_state", {30'd0, flash_state}, 32'd1);
        pix(0, 3, 1'b0, 12'hFFF); nxt();
        idle(2);
        frame_tick = 1'b1; nxt();
        check("restart_tick_active", {31'd0, flash_active}, 32'd1);
        check("restart_tick_state", {30'd0, flash_state}, 32'd2);
        pix(0, 3, 1'b0, 12'hEEC); nxt();
        idle(3);

        // Asynchronous reset mid-stream and mid-flash
        wr(0, 1, 12'h123); nxt();
        pix(0, 1, 1'b0, 12'h123); nxt();
        idle(3);
        flash_start = 1'b1; nxt();
        pix(0, 1, 1'b0, 12'hFFF); nxt();
        pix_noexp(0, 7); nxt();
        pix_noexp(0, 9);
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {27'd0, pix_valid_out, transparent, red, green, blue}, 32'd0);
        check("async_reset_flash_active", {31'd0, flash_active}, 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
        clear_inputs();
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        nxt();
        check("post_reset_flash_active", {31'd0, flash_active}, 32'd0);
        pix(0, 1, 1'b0, 12'hBA9); nxt();
        pix(1, 5, 1'b0, 12'hA76); nxt();
        pix(0, 3, 1'b0, 12'hEEC); nxt();
        idle(3);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge Clk);
            waited++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pixels outstanding expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
